// File: rtl/data_memory_stage_lsu.sv
// MEM-stage load/store unit: single-outstanding data-bus access, load lane
// extraction and extension, pass-through of non-memory results.
// Optional feature macro: LSU_EXCEPTION_EN (report misaligned/illegal ops
// instead of silently aligning or widening them).
module data_memory_stage_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_load,
  input  logic                      ex_store,
  input  logic [2:0]                ex_funct3,
  input  logic [ADDR_WIDTH-1:0]     ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic [4:0]                ex_rd,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic                      wb_we,
  output logic [4:0]                wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      exc_valid,
  output logic [1:0]                exc_cause,
  output logic [ADDR_WIDTH-1:0]     exc_addr
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam bit          IS64 = (DATA_WIDTH == 64);
`ifndef LSU_EXCEPTION_EN
  localparam logic [2:0]  F3_FULL = IS64 ? 3'b011 : 3'b010;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            state, state_d;
  logic                  mem_req_d, mem_we_d, wb_valid_d, wb_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, wb_data_d;
  logic [NB-1:0]         mem_be_d;
  logic [4:0]            wb_rd_d;
  logic                  op_store, op_store_d;
  logic [2:0]            op_funct3, op_funct3_d;
  logic [OFFW-1:0]       op_off, op_off_d;

  logic                  ex_fire;
  logic                  ld_ok, st_ok, dec_mem, dec_illegal;
  logic [2:0]            dec_funct3;
  logic [1:0]            dec_size;
  logic [OFFW-1:0]       size_mask, dec_off;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [NB-1:0]         be_base, dec_be;
  logic [DATA_WIDTH-1:0] dec_wdata, rd_shift, rd_ext;

  assign ex_ready = (state == S_IDLE) || ((state == S_HOLD) && wb_ready);
  assign ex_fire  = ex_valid && ex_ready;

`ifdef LSU_EXCEPTION_EN
  logic                  dec_misal, dec_exc;
  logic                  exc_valid_d;
  logic [1:0]            exc_cause_d;
  logic [ADDR_WIDTH-1:0] exc_addr_d;
`else
  assign exc_valid = 1'b0;
  assign exc_cause = 2'd0;
  assign exc_addr  = '0;
`endif

  // Decode the offered op: legality, access size, aligned address, lanes
  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: begin ld_ok = 1'b1; st_ok = 1'b1; end
      3'b100, 3'b101:         ld_ok = 1'b1;
      3'b011:                 begin ld_ok = IS64; st_ok = IS64; end
      3'b110:                 ld_ok = IS64;
      default: ;
    endcase
    dec_mem     = ex_load || ex_store;
    dec_illegal = (ex_load && ex_store) || (ex_load && !ld_ok) || (ex_store && !st_ok);
    dec_funct3  = ex_funct3;
`ifndef LSU_EXCEPTION_EN
    // Illegal ops degrade to a full-width access of the requested direction
    if (dec_illegal) dec_funct3 = F3_FULL;
`endif
    dec_size  = dec_funct3[1:0];
    size_mask = OFFW'((1 << dec_size) - 1);
`ifdef LSU_EXCEPTION_EN
    dec_misal = (ex_addr[OFFW-1:0] & size_mask) != '0;
    dec_exc   = dec_illegal || (dec_mem && dec_misal);
    dec_off   = ex_addr[OFFW-1:0];
`else
    dec_off   = ex_addr[OFFW-1:0] & ~size_mask;
`endif
    dec_addr = {ex_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
    case (dec_size)
      2'd0:    be_base = NB'(1);
      2'd1:    be_base = NB'(3);
      2'd2:    be_base = NB'(15);
      default: be_base = NB'(255);
    endcase
    dec_be = be_base << dec_off;
    case (dec_size)
      2'd0:    dec_wdata = {NB{ex_wdata[7:0]}};
      2'd1:    dec_wdata = {(NB/2){ex_wdata[15:0]}};
      2'd2:    dec_wdata = {(NB/4){ex_wdata[31:0]}};
      default: dec_wdata = ex_wdata;
    endcase
  end

  // Extract the addressed lane from read data and extend it
  always_comb begin
    rd_shift = mem_rdata >> {op_off, 3'b000};
    case (op_funct3)
      3'b000:  rd_ext = DATA_WIDTH'($signed(rd_shift[7:0]));
      3'b001:  rd_ext = DATA_WIDTH'($signed(rd_shift[15:0]));
      3'b010:  rd_ext = DATA_WIDTH'($signed(rd_shift[31:0]));
      3'b100:  rd_ext = DATA_WIDTH'(rd_shift[7:0]);
      3'b101:  rd_ext = DATA_WIDTH'(rd_shift[15:0]);
      3'b110:  rd_ext = DATA_WIDTH'(rd_shift[31:0]);
      default: rd_ext = rd_shift;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    wb_valid_d  = wb_valid;
    wb_we_d     = wb_we;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    op_store_d  = op_store;
    op_funct3_d = op_funct3;
    op_off_d    = op_off;
`ifdef LSU_EXCEPTION_EN
    exc_valid_d = exc_valid;
    exc_cause_d = exc_cause;
    exc_addr_d  = exc_addr;
`endif
    case (state)
      S_BUS: if (mem_ack) begin
        state_d    = S_HOLD;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_we_d    = !op_store && (wb_rd != 5'd0);
        wb_data_d  = op_store ? '0 : rd_ext;
      end
      S_HOLD: if (wb_ready) begin
        state_d    = S_IDLE;
        wb_valid_d = 1'b0;
`ifdef LSU_EXCEPTION_EN
        exc_valid_d = 1'b0;
`endif
      end
      default: ;
    endcase
    if (ex_fire) begin
      wb_rd_d     = ex_rd;
      op_store_d  = ex_store;
      op_funct3_d = dec_funct3;
      op_off_d    = dec_off;
`ifdef LSU_EXCEPTION_EN
      exc_valid_d = 1'b0;
      exc_cause_d = 2'd0;
      if (dec_exc) begin
        state_d     = S_HOLD;
        wb_valid_d  = 1'b1;
        wb_we_d     = 1'b0;
        wb_data_d   = '0;
        exc_valid_d = 1'b1;
        exc_cause_d = dec_illegal ? 2'd2 : 2'd1;
        exc_addr_d  = ex_addr;
      end else
`endif
      if (dec_mem) begin
        state_d     = S_BUS;
        mem_req_d   = 1'b1;
        mem_we_d    = ex_store;
        mem_addr_d  = dec_addr;
        mem_wdata_d = dec_wdata;
        mem_be_d    = dec_be;
        wb_valid_d  = 1'b0;
      end else begin
        state_d    = S_HOLD;
        wb_valid_d = 1'b1;
        wb_we_d    = (ex_rd != 5'd0);
        wb_data_d  = DATA_WIDTH'(ex_addr);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      op_store  <= 1'b0;
      op_funct3 <= 3'd0;
      op_off    <= '0;
`ifdef LSU_EXCEPTION_EN
      exc_valid <= 1'b0;
      exc_cause <= 2'd0;
      exc_addr  <= '0;
`endif
    end else begin
      state     <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      wb_valid  <= wb_valid_d;
      wb_we     <= wb_we_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      op_store  <= op_store_d;
      op_funct3 <= op_funct3_d;
      op_off    <= op_off_d;
`ifdef LSU_EXCEPTION_EN
      exc_valid <= exc_valid_d;
      exc_cause <= exc_cause_d;
      exc_addr  <= exc_addr_d;
`endif
    end
  end

endmodule
